// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/indirect/execute control sequencer; optional interrupt cycle via SEQ_INTERRUPT_EN
module instr_sequencer #(
    parameter int ADDR_W       = 12,
    parameter bit RESET_PC_CLR = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] IR,
    input  logic        memRDY,
    input  logic        AC_NEG,
    input  logic        AC_ZERO,
    input  logic        E_ZERO,
    input  logic        DR_ZERO,
`ifdef SEQ_INTERRUPT_EN
    input  logic        INTR,
    output logic        intAR0,
`endif
    output logic        irLD,
    output logic        irCLR,
    output logic        arLD,
    output logic [1:0]  arSrc,
    output logic        arINR,
    output logic        pcLD,
    output logic        pcINR,
    output logic        pcCLR,
    output logic        memRD,
    output logic        memWR,
    output logic [1:0]  wrSrc,
    output logic        drLD,
    output logic        drINR,
    output logic [3:0]  aluOp,
    output logic        acLD,
    output logic        halted,
    output logic [3:0]  state
);
    typedef enum logic [3:0] {
        F0, F1, DEC, IND, EX0, EX1, EX2, RR, HALT
`ifdef SEQ_INTERRUPT_EN
        , INT0, INT1
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] top;
`ifdef SEQ_INTERRUPT_EN
    logic       ien_q, ien_d;
`endif

    assign state = state_q;

    // Next-state and strobe decode; reset overrides everything at the end
    always_comb begin
        irLD    = 1'b0;
        irCLR   = 1'b0;
        arLD    = 1'b0;
        arSrc   = 2'd0;
        arINR   = 1'b0;
        pcLD    = 1'b0;
        pcINR   = 1'b0;
        pcCLR   = 1'b0;
        memRD   = 1'b0;
        memWR   = 1'b0;
        wrSrc   = 2'd0;
        drLD    = 1'b0;
        drINR   = 1'b0;
        aluOp   = 4'd0;
        acLD    = 1'b0;
        halted  = 1'b0;
`ifdef SEQ_INTERRUPT_EN
        intAR0  = 1'b0;
        ien_d   = ien_q;
`endif
        state_d = state_q;
        top     = 4'hF;
        for (int b = 0; b < ADDR_W; b++) if (IR[b]) top = 4'(b);
        case (state_q)
            F0: begin
                arLD    = 1'b1;
                state_d = F1;
            end
            F1: begin
                memRD = 1'b1;
                if (memRDY) begin
                    irLD    = 1'b1;
                    pcINR   = 1'b1;
                    state_d = DEC;
                end
            end
            DEC: begin
                if (IR[14:12] != 3'd7) begin
                    arLD    = 1'b1;
                    arSrc   = 2'd1;
                    state_d = IR[15] ? IND : EX0;
                end else begin
                    state_d = RR;
                end
            end
            IND: begin
                memRD = 1'b1;
                if (memRDY) begin
                    arLD    = 1'b1;
                    arSrc   = 2'd2;
                    state_d = EX0;
                end
            end
            EX0: begin
                case (IR[14:12])
                    3'd0, 3'd1, 3'd2, 3'd6: begin
                        memRD = 1'b1;
                        if (memRDY) begin
                            drLD    = 1'b1;
                            state_d = EX1;
                        end
                    end
                    3'd3: begin
                        memWR = 1'b1;
                        if (memRDY) state_d = F0;
                    end
                    3'd4: begin
                        pcLD    = 1'b1;
                        state_d = F0;
                    end
                    3'd5: begin
                        memWR = 1'b1;
                        wrSrc = 2'd2;
                        if (memRDY) begin
                            arINR   = 1'b1;
                            state_d = EX1;
                        end
                    end
                    default: state_d = F0;
                endcase
            end
            EX1: begin
                if (IR[14:12] == 3'd6) begin
                    drINR   = 1'b1;
                    state_d = EX2;
                end else if (IR[14:12] == 3'd5) begin
                    pcLD    = 1'b1;
                    state_d = F0;
                end else begin
                    aluOp   = {1'b0, IR[14:12]} + 4'd1;
                    acLD    = 1'b1;
                    state_d = F0;
                end
            end
            EX2: begin
                memWR = 1'b1;
                wrSrc = 2'd1;
                if (memRDY) begin
                    pcINR   = DR_ZERO;
                    state_d = F0;
                end
            end
            RR: begin
                state_d = F0;
                if (!IR[15]) begin
                    if (top >= 4'd5 && top <= 4'd11) begin
                        aluOp = 4'd15 - top;
                        acLD  = 1'b1;
                    end
                    pcINR = (top == 4'd4 && !AC_NEG) || (top == 4'd3 && AC_NEG) ||
                            (top == 4'd2 && AC_ZERO) || (top == 4'd1 && E_ZERO);
                    if (top == 4'd0) state_d = HALT;
                end
`ifdef SEQ_INTERRUPT_EN
                else begin
                    if (IR == 16'hF080) ien_d = 1'b1;
                    if (IR == 16'hF040) ien_d = 1'b0;
                end
`endif
            end
            HALT: halted = 1'b1;
`ifdef SEQ_INTERRUPT_EN
            INT0: begin
                arLD    = 1'b1;
                arSrc   = 2'd1;
                intAR0  = 1'b1;
                pcCLR   = 1'b1;
                state_d = INT1;
            end
            INT1: begin
                memWR = 1'b1;
                wrSrc = 2'd2;
                if (memRDY) begin
                    pcINR   = 1'b1;
                    ien_d   = 1'b0;
                    state_d = F0;
                end
            end
`endif
            default: state_d = F0;
        endcase
`ifdef SEQ_INTERRUPT_EN
        if (state_d == F0 && ien_d && INTR) state_d = INT0;
`endif
        if (!RST_N) begin
            irLD   = 1'b0;
            irCLR  = 1'b1;
            arLD   = 1'b0;
            arSrc  = 2'd0;
            arINR  = 1'b0;
            pcLD   = 1'b0;
            pcINR  = 1'b0;
            pcCLR  = RESET_PC_CLR;
            memRD  = 1'b0;
            memWR  = 1'b0;
            wrSrc  = 2'd0;
            drLD   = 1'b0;
            drINR  = 1'b0;
            aluOp  = 4'd0;
            acLD   = 1'b0;
            halted = 1'b0;
`ifdef SEQ_INTERRUPT_EN
            intAR0 = 1'b0;
`endif
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= F0;
`ifdef SEQ_INTERRUPT_EN
            ien_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef SEQ_INTERRUPT_EN
            ien_q   <= ien_d;
`endif
        end
    end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: instruction-level trace model driving and checking instr_sequencer every cycle
module tb_instr_sequencer;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] IR = 16'h0;
    logic        memRDY = 1'b0;
    logic        AC_NEG = 1'b0, AC_ZERO = 1'b0, E_ZERO = 1'b0, DR_ZERO = 1'b0;
    logic        irLD, irCLR, arLD, arINR, pcLD, pcINR, pcCLR, memRD, memWR, drLD, drINR, acLD, halted;
    logic [1:0]  arSrc, wrSrc;
    logic [3:0]  aluOp, state;
    logic        ia;

    always #5 CLK = ~CLK;

`ifdef SEQ_INTERRUPT_EN
    logic INTR = 1'b0;
    logic intAR0;
    assign ia = intAR0;
`else
    assign ia = 1'b0;
`endif

    instr_sequencer dut (
        .CLK(CLK), .RST_N(RST_N), .IR(IR), .memRDY(memRDY),
        .AC_NEG(AC_NEG), .AC_ZERO(AC_ZERO), .E_ZERO(E_ZERO), .DR_ZERO(DR_ZERO),
`ifdef SEQ_INTERRUPT_EN
        .INTR(INTR), .intAR0(intAR0),
`endif
        .irLD(irLD), .irCLR(irCLR), .arLD(arLD), .arSrc(arSrc), .arINR(arINR),
        .pcLD(pcLD), .pcINR(pcINR), .pcCLR(pcCLR), .memRD(memRD), .memWR(memWR),
        .wrSrc(wrSrc), .drLD(drLD), .drINR(drINR), .aluOp(aluOp), .acLD(acLD),
        .halted(halted), .state(state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       irLD, irCLR, arLD;
        logic [1:0] arSrc;
        logic       arINR, pcLD, pcINR, pcCLR, memRD, memWR;
        logic [1:0] wrSrc;
        logic       drLD, drINR;
        logic [3:0] aluOp;
        logic       acLD, halted, intAR0;
    } out_t;

    typedef struct {
        out_t        o;
        logic        rst, rdy, an, az, ez, dz, intr, chk;
        logic [15:0] ir;
    } cyc_t;

    out_t act;
    assign act = {state, irLD, irCLR, arLD, arSrc, arINR, pcLD, pcINR, pcCLR,
                  memRD, memWR, wrSrc, drLD, drINR, aluOp, acLD, halted, ia};

    cyc_t        q[$];
    cyc_t        cur;
    int          idx;
    bit          active = 1'b0;
    int          n_chk = 0, n_err = 0;
    logic [15:0] g_ir = 16'h0;
    logic        g_an = 0, g_az = 0, g_ez = 0, g_dz = 0, g_intr = 0;
    bit          m_ien = 0;

    function automatic out_t z(input logic [3:0] st);
        out_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    task automatic push(input out_t o, input logic rdy);
        cyc_t c;
        c.o = o; c.rst = 1'b0; c.rdy = rdy; c.ir = g_ir; c.chk = 1'b1;
        c.an = g_an; c.az = g_az; c.ez = g_ez; c.dz = g_dz; c.intr = g_intr;
        q.push_back(c);
    endtask

    task automatic push_rst(input logic [3:0] st, input logic chk, input logic rdy);
        cyc_t c;
        c.o = z(st); c.o.irCLR = 1'b1; c.o.pcCLR = 1'b1;
        c.rst = 1'b1; c.rdy = rdy; c.ir = g_ir; c.chk = chk;
        c.an = g_an; c.az = g_az; c.ez = g_ez; c.dz = g_dz; c.intr = g_intr;
        q.push_back(c);
        m_ien = 0;
    endtask

    task automatic acc(input out_t hold, input out_t done, input int w);
        repeat (w) push(hold, 1'b0);
        push(done, 1'b1);
    endtask

    task automatic setf(input logic an, input logic az, input logic ez, input logic dz, input logic intr);
        g_an = an; g_az = az; g_ez = ez; g_dz = dz; g_intr = intr;
    endtask

    // expected cycle trace of one instruction; w = wait cycles before every memRDY
    task automatic instr(input logic [15:0] ir, input int w);
        out_t a, b;
        logic [2:0] op;
        int top;
        bit hlt;
        g_ir = ir; op = ir[14:12]; hlt = 0;
        a = z(0); a.arLD = 1; push(a, 1'b1);
        a = z(1); a.memRD = 1; b = a; b.irLD = 1; b.pcINR = 1; acc(a, b, w);
        if (op != 3'd7) begin
            a = z(2); a.arLD = 1; a.arSrc = 2'd1; push(a, 1'b1);
            if (ir[15]) begin
                a = z(3); a.memRD = 1; b = a; b.arLD = 1; b.arSrc = 2'd2; acc(a, b, w);
            end
            if (op <= 3'd2 || op == 3'd6) begin
                a = z(4); a.memRD = 1; b = a; b.drLD = 1; acc(a, b, w);
                if (op == 3'd6) begin
                    a = z(5); a.drINR = 1; push(a, 1'b1);
                    a = z(6); a.memWR = 1; a.wrSrc = 2'd1; b = a; b.pcINR = g_dz; acc(a, b, w);
                end else begin
                    a = z(5); a.aluOp = 4'(op) + 4'd1; a.acLD = 1; push(a, 1'b1);
                end
            end else if (op == 3'd3) begin
                a = z(4); a.memWR = 1; acc(a, a, w);
            end else if (op == 3'd4) begin
                a = z(4); a.pcLD = 1; push(a, 1'b1);
            end else begin
                a = z(4); a.memWR = 1; a.wrSrc = 2'd2; b = a; b.arINR = 1; acc(a, b, w);
                a = z(5); a.pcLD = 1; push(a, 1'b1);
            end
        end else begin
            push(z(2), 1'b1);
            a = z(7);
            if (!ir[15]) begin
                top = -1;
                for (int k = 11; k >= 0; k--) if (ir[k]) begin top = k; break; end
                if (top >= 5) begin a.aluOp = 4'(15 - top); a.acLD = 1; end
                else if (top == 4) a.pcINR = !g_an;
                else if (top == 3) a.pcINR = g_an;
                else if (top == 2) a.pcINR = g_az;
                else if (top == 1) a.pcINR = g_ez;
                else if (top == 0) hlt = 1;
            end
`ifdef SEQ_INTERRUPT_EN
            else if (ir == 16'hF080) m_ien = 1;
            else if (ir == 16'hF040) m_ien = 0;
`endif
            push(a, 1'b1);
        end
        if (hlt) begin
            a = z(8); a.halted = 1;
            repeat (20) push(a, 1'b1);
        end
`ifdef SEQ_INTERRUPT_EN
        else if (m_ien && g_intr) begin
            a = z(9); a.arLD = 1; a.arSrc = 2'd1; a.pcCLR = 1; a.intAR0 = 1; push(a, 1'b1);
            a = z(10); a.memWR = 1; a.wrSrc = 2'd2; b = a; b.pcINR = 1; acc(a, b, w);
            m_ien = 0;
        end
`endif
    endtask

    task automatic pin(input string name, input int a, input int e);
        n_chk++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, a, e);
        end
    endtask

    // per-cycle comparison of every DUT output against the trace model
    always @(negedge CLK) begin
        if (active && cur.chk) begin
            n_chk++;
            if (act !== cur.o) begin
                n_err++;
                $display("FAIL cycle %0d st=%0d ir=%h: got %h want %h", idx, cur.o.st, cur.ir, act, cur.o);
            end
        end
    end

    initial begin
        int s, n;
        out_t a;
        push_rst(4'd0, 1'b0, 1'b1);
        push_rst(4'd0, 1'b1, 1'b1);
        s = q.size(); instr(16'h2005, 0);
        pin("lda_len", q.size() - s, 5);
        pin("lda_ex0_drLD", int'(q[s+3].o.drLD), 1);
        pin("lda_ex1_aluOp", int'(q[s+4].o.aluOp), 3);
        pin("lda_ex1_acLD", int'(q[s+4].o.acLD), 1);
        s = q.size(); instr(16'h9010, 2);
        n = 0;
        for (int i = s; i < q.size(); i++) if (q[i].o.st == 4'd3 && q[i].o.memRD) n++;
        pin("add_ind_memRD_cycles", n, 3);
        pin("add_ex1_aluOp", int'(q[q.size()-1].o.aluOp), 2);
        instr(16'h0123, 1);
        s = q.size(); instr(16'h3044, 0);
        pin("sta_len", q.size() - s, 4);
        instr(16'h3044, 1);
        instr(16'h4100, 0);
        instr(16'h5200, 1);
        setf(0, 0, 0, 1, 0);
        s = q.size(); instr(16'h6020, 0);
        pin("isz_len", q.size() - s, 6);
        pin("isz_skip_pcINR", int'(q[q.size()-1].o.pcINR), 1);
        pin("isz_wrSrc", int'(q[q.size()-1].o.wrSrc), 1);
        setf(0, 0, 0, 0, 0);
        instr(16'h6020, 1);
        pin("isz_noskip_pcINR", int'(q[q.size()-1].o.pcINR), 0);
        s = q.size(); instr(16'h7010, 0);
        pin("rr_len", q.size() - s, 4);
        pin("spa_pcINR", int'(q[q.size()-1].o.pcINR), 1);
        instr(16'h7800, 0); instr(16'h7400, 0); instr(16'h7200, 0); instr(16'h7100, 0);
        instr(16'h7080, 0); instr(16'h7040, 0); instr(16'h7020, 0); instr(16'h7C00, 0);
        instr(16'h7011, 0); instr(16'h7000, 0);
        setf(1, 0, 0, 0, 0); instr(16'h7010, 0); instr(16'h7008, 0);
        setf(0, 0, 0, 0, 0); instr(16'h7008, 0); instr(16'h7004, 0); instr(16'h7002, 0);
        setf(0, 1, 1, 0, 0); instr(16'h7004, 0); instr(16'h7002, 0);
`ifndef SEQ_INTERRUPT_EN
        instr(16'hF080, 0); instr(16'hF040, 0);
`endif
        setf(0, 0, 0, 0, 0);
        g_ir = 16'h2005;
        a = z(0); a.arLD = 1; push(a, 1'b1);
        a = z(1); a.memRD = 1; push(a, 1'b0); push(a, 1'b0);
        push_rst(4'd1, 1'b1, 1'b0);
        instr(16'h2005, 0);
        instr(16'h7001, 1);
        pin("hlt_halted", int'(q[q.size()-1].o.halted), 1);
        push_rst(4'd8, 1'b1, 1'b1);
        instr(16'h3010, 0);
`ifdef SEQ_INTERRUPT_EN
        setf(0, 0, 0, 0, 0); instr(16'hF080, 0);
        setf(0, 0, 0, 0, 1);
        s = q.size(); instr(16'h7000, 1);
        pin("int_entry_len", q.size() - s, 8);
        instr(16'h7000, 0);
        setf(0, 0, 0, 0, 0); instr(16'hF080, 0);
        setf(0, 0, 0, 0, 1); instr(16'hF040, 0); instr(16'h7000, 0);
        setf(0, 0, 0, 0, 0);
`endif
        foreach (q[i]) begin
            @(posedge CLK);
            #1;
            cur = q[i];
            idx = i;
            RST_N = !cur.rst;
            memRDY = cur.rdy;
            IR = cur.ir;
            AC_NEG = cur.an; AC_ZERO = cur.az; E_ZERO = cur.ez; DR_ZERO = cur.dz;
`ifdef SEQ_INTERRUPT_EN
            INTR = cur.intr;
`endif
            active = 1'b1;
        end
        @(posedge CLK);
        #1;
        active = 1'b0;
        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
